// File: rtl/scfifo_pkg.sv
// scfifo_pkg: shared types and the rotating-priority search used by the scfifo arbiters.
package scfifo_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {IDLE, BURST} state_e;

    typedef struct packed {
        logic                 any;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_IDX_W = req_idx_w(4);

    // Walk downward so the last hit kept is the first set bit above ptr, wrapping mod n.
    function automatic pick_t rr_search(input logic [MAX_REQ-1:0] req, input int n,
                                        input logic [MAX_IDX_W-1:0] ptr);
        pick_t                p;
        logic [MAX_IDX_W-1:0] j;
        p = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            j = MAX_IDX_W'((int'(ptr) + k) % n);
            if (k <= n && req[j]) begin
                p.any = 1'b1;
                p.idx = j;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/scfifo_wr_arb_rr_pick.sv
// rr_pick: combinational rotating-priority encoder, highest priority just above rr_ptr.
module rr_pick
    import scfifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    pick_t p;

    assign p      = rr_search(MAX_REQ'(req), NUM_REQ, MAX_IDX_W'(rr_ptr));
    assign winner = IDX_W'(p.idx);
    assign any    = p.any;

endmodule

// File: rtl/scfifo_wr_arb.sv
// scfifo_wr_arb: round-robin burst arbiter sharing one scfifo write port among NUM_REQ producers.
module scfifo_wr_arb
    import scfifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int I_WIDTH   = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*I_WIDTH-1:0]   req_din,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic                         fifo_wr_en,
    output logic [I_WIDTH-1:0]           fifo_din,
    input  logic                         fifo_full,
    input  logic                         fifo_clr,
    output logic                         busy,
    output logic [req_idx_w(NUM_REQ)-1:0] grant_id
);

    localparam int IW = req_idx_w(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic [IW-1:0]      grant_id_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [CW-1:0]      burst_cnt_q;
    logic [IW-1:0]      winner;
    logic               any;
    logic               req_g;
    logic               xfer;
    logic               done;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IW)) u_pick (
        .req   (req),
        .rr_ptr(rr_ptr_q),
        .winner(winner),
        .any   (any)
    );

    assign req_g      = req[grant_id_q];
    assign xfer       = (state_q == BURST) && req_g && !fifo_full;
    assign done       = !req_g || (xfer && (req_last[grant_id_q] || burst_cnt_q == CW'(MAX_BURST - 1)));
    assign fifo_wr_en = xfer;
    assign req_ack    = xfer ? gnt_q : '0;
    assign fifo_din   = req_din[grant_id_q*I_WIDTH +: I_WIDTH];
    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

    // fifo_clr behaves like reset but keeps grant_id pointing at the last grantee.
    always_ff @(posedge clk) begin
        if (!rst_n || fifo_clr) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            if (!rst_n) grant_id_q <= '0;
        end else if (state_q == IDLE) begin
            if (any) begin
                state_q     <= BURST;
                gnt_q       <= NUM_REQ'(1) << winner;
                busy_q      <= 1'b1;
                grant_id_q  <= winner;
                burst_cnt_q <= '0;
            end
        end else if (done) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= grant_id_q;
        end else if (xfer) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_scfifo_wr_arb.sv
// tb_scfifo_wr_arb: randomized traffic against a cycle-level reference of the arbitration rules.
module tb_scfifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_din;
    logic [N-1:0]   req_last;
    logic [N-1:0]   gnt;
    logic [N-1:0]   req_ack;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_din;
    logic           fifo_full;
    logic           fifo_clr;
    logic           busy;
    logic [IW-1:0]  grant_id;

    always #5 clk = ~clk;

    scfifo_wr_arb #(.NUM_REQ(N), .I_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_din   (req_din),
        .req_last  (req_last),
        .gnt       (gnt),
        .req_ack   (req_ack),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .fifo_clr  (fifo_clr),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int owner = -1;
    int cnt   = 0;
    int rr    = N - 1;
    int gid   = 0;
    int seq[N];
    bit acked[N];

    function automatic logic [W-1:0] word(input int i);
        return {8'(i), 24'(seq[i])};
    endfunction

    task automatic step(input int p_req, input int p_drop, input int p_last,
                        input int p_full, input int p_clr, input int p_rst);
        logic [N-1:0] exp_gnt;
        bit           xf;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!req[i] || acked[i]) req[i] = ($urandom_range(99) < p_req);
            else if ($urandom_range(99) < p_drop) req[i] = 1'b0;
            req_last[i] = ($urandom_range(99) < p_last);
            req_din[i*W +: W] = word(i);
            acked[i] = 1'b0;
        end
        fifo_full = ($urandom_range(99) < p_full);
        fifo_clr  = ($urandom_range(99) < p_clr);
        rst_n     = !($urandom_range(99) < p_rst);
        #1;
        exp_gnt = (owner >= 0) ? (N'(1) << owner) : '0;
        xf      = (owner >= 0) && req[owner] && !fifo_full;
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("grant_id", 64'(grant_id), 64'(gid));
        chk("wr_en", 64'(fifo_wr_en), 64'(xf));
        chk("ack", 64'(req_ack), xf ? 64'(exp_gnt) : 64'd0);
        if (xf) chk("din", 64'(fifo_din), 64'(word(owner)));
        chk("onehot", 64'($onehot0(gnt)), 64'd1);
        chk("no_ovf", 64'(fifo_wr_en & fifo_full), 64'd0);
        chk("ack_sub", 64'(|(req_ack & ~gnt)), 64'd0);
        if (xf) begin
            acked[owner] = 1'b1;
            seq[owner]++;
        end
        if (!rst_n) begin
            owner = -1; cnt = 0; rr = N - 1; gid = 0;
        end else if (fifo_clr) begin
            owner = -1; cnt = 0; rr = N - 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++)
                if (owner < 0 && req[(rr + k) % N]) begin
                    owner = (rr + k) % N;
                    gid   = owner;
                    cnt   = 0;
                end
        end else if (!req[owner] || (xf && (req_last[owner] || cnt + 1 == MB))) begin
            rr    = owner;
            owner = -1;
        end else if (xf) begin
            cnt++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        fifo_clr  = 1'b0;
        fifo_full = 1'b0;
        req       = '0;
        req_last  = '0;
        req_din   = '0;
        for (int i = 0; i < N; i++) begin
            seq[i]   = 0;
            acked[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        for (int seg = 0; seg < 10; seg++) begin
            for (int c = 0; c < 1000; c++) begin
                case (seg % 5)
                    0:       step(100, 0, 0, 0, 0, 0);
                    1:       step(60, 5, 25, 30, 0, 0);
                    2:       step(90, 2, 10, 70, 0, 0);
                    3:       step(30, 10, 40, 10, 2, 1);
                    default: step(100, 0, 0, 20, 1, 0);
                endcase
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
